// File: rtl/dlsc_axi_router_wr_channel_pkg.sv
// Shared types and sizing helpers for the router write-data channel stage.
package dlsc_axi_router_wr_channel_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } wr_state_t;

    function automatic int strb_width(input int data);
        return data / 8;
    endfunction

    function automatic int fifo_depth(input int addr);
        return 1 << addr;
    endfunction

endpackage

// File: rtl/dlsc_axi_router_cmd_fifo.sv
// Synchronous show-ahead command FIFO with occupancy count and programmable almost-full.
module dlsc_axi_router_cmd_fifo
    import dlsc_axi_router_wr_channel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ADDR  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    input  logic [ADDR:0]    almost_full_thresh,
    output logic [ADDR:0]    count,
    output logic             almost_full,
    output logic             empty
);
    localparam int DEPTH = fifo_depth(ADDR);
    localparam logic [ADDR:0]   CNT_FULL = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0]   CNT_ONE  = (ADDR+1)'(1);
    localparam logic [ADDR-1:0] PTR_ONE  = ADDR'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR-1:0]  wr_ptr, rd_ptr;
    logic             push_en, pop_en;

    // Pushes into a full FIFO are dropped so the occupancy can never exceed DEPTH.
    assign push_en = push && (count != CNT_FULL);
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push_en && !pop_en)      count <= count + CNT_ONE;
            else if (!push_en && pop_en) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

    assign pop_data    = mem[rd_ptr];
    assign empty       = (count == '0);
    assign almost_full = (count >= almost_full_thresh);

endmodule

// File: rtl/dlsc_axi_router_wr_channel.sv
// Router W-channel stage: steers whole bursts from input to output in command order.
// Optional DLSC_AXI_ROUTER_WR_LEN_CHECK_EN: last derived from cmd_len, sticky err_len on disagreement.
module dlsc_axi_router_wr_channel
    import dlsc_axi_router_wr_channel_pkg::*;
#(
    parameter int DATA      = 32,
    parameter int LEN       = 4,
    parameter int INPUTS    = 1,
    parameter int INPUTSB   = 1,
    parameter int OUTPUTS   = 1,
    parameter int OUTPUTSB  = 1,
    parameter int FIFO_ADDR = 2,
    localparam int STRB     = strb_width(DATA)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [INPUTS-1:0]       cmd_full_input,
    output logic [OUTPUTS-1:0]      cmd_full_output,
    input  logic                    cmd_push,
    input  logic [INPUTSB-1:0]      cmd_input,
    input  logic [OUTPUTSB-1:0]     cmd_output,
    input  logic [LEN-1:0]          cmd_len,
`ifdef DLSC_AXI_ROUTER_WR_LEN_CHECK_EN
    output logic                    err_len,
`endif
    output logic [INPUTS-1:0]       in_w_ready,
    input  logic [INPUTS-1:0]       in_w_valid,
    input  logic [INPUTS-1:0]       in_w_last,
    input  logic [INPUTS*DATA-1:0]  in_w_data,
    input  logic [INPUTS*STRB-1:0]  in_w_strb,
    input  logic [OUTPUTS-1:0]      out_w_ready,
    output logic [OUTPUTS-1:0]      out_w_valid,
    output logic [OUTPUTS-1:0]      out_w_last,
    output logic [OUTPUTS*DATA-1:0] out_w_data,
    output logic [OUTPUTS*STRB-1:0] out_w_strb
);
    localparam int CW    = INPUTSB + OUTPUTSB + LEN;
    localparam int DEPTH = fifo_depth(FIFO_ADDR);
    localparam logic [FIFO_ADDR:0] CNT_FULL  = (FIFO_ADDR+1)'(DEPTH);
    localparam logic [FIFO_ADDR:0] AF_THRESH = (FIFO_ADDR+1)'(DEPTH - 1);

    logic [CW-1:0]        fifo_dout;
    logic [FIFO_ADDR:0]   fifo_count;
    logic                 fifo_af, fifo_empty, fifo_pop;
    logic [INPUTSB-1:0]   fifo_in;
    logic [OUTPUTSB-1:0]  fifo_out;
    logic [LEN-1:0]       fifo_len;

    wr_state_t            state, next_state;
    logic [INPUTSB-1:0]   sel_in;
    logic [OUTPUTSB-1:0]  sel_out;
    logic                 in_done;
    logic                 obuf_valid, obuf_last, obuf_ready;
    logic [DATA-1:0]      obuf_data;
    logic [STRB-1:0]      obuf_strb;
    logic                 in_rdy, in_hs, beat_last;

    dlsc_axi_router_cmd_fifo #(
        .WIDTH (CW),
        .ADDR  (FIFO_ADDR)
    ) u_cmd_fifo (
        .clk                (clk),
        .rst                (rst),
        .push               (cmd_push),
        .push_data          ({cmd_input, cmd_output, cmd_len}),
        .pop                (fifo_pop),
        .pop_data           (fifo_dout),
        .almost_full_thresh (AF_THRESH),
        .count              (fifo_count),
        .almost_full        (fifo_af),
        .empty              (fifo_empty)
    );

    assign {fifo_in, fifo_out, fifo_len} = fifo_dout;
    // The threshold sits one below depth to absorb the push already in flight upstream.
    assign cmd_full_input  = {INPUTS{fifo_af}};
    assign cmd_full_output = {OUTPUTS{fifo_af}};

    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
    assign obuf_ready = !obuf_valid || out_w_ready[sel_out];
    assign in_rdy     = (state == ST_ACTIVE) && !in_done && obuf_ready && !rst;
    assign in_hs      = in_rdy && in_w_valid[sel_in];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Leaving ACTIVE waits for the last beat to drain so sel_out stays stable under obuf_valid.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (!fifo_empty) next_state = ST_ACTIVE;
            ST_ACTIVE: if (in_done && obuf_ready) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_in     <= '0;
            sel_out    <= '0;
            in_done    <= 1'b0;
            obuf_valid <= 1'b0;
            obuf_last  <= 1'b0;
        end else begin
            if (fifo_pop) begin
                sel_in  <= fifo_in;
                sel_out <= fifo_out;
                in_done <= 1'b0;
            end
            if (in_hs) begin
                obuf_valid <= 1'b1;
                obuf_last  <= beat_last;
                if (beat_last) in_done <= 1'b1;
            end else if (out_w_ready[sel_out]) begin
                obuf_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs) begin
            obuf_data <= in_w_data[sel_in*DATA +: DATA];
            obuf_strb <= in_w_strb[sel_in*STRB +: STRB];
        end
    end

`ifdef DLSC_AXI_ROUTER_WR_LEN_CHECK_EN
    logic [LEN-1:0] beat_cnt, len_r;

    assign beat_last = (beat_cnt == len_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            err_len  <= 1'b0;
        end else begin
            if (fifo_pop) begin
                beat_cnt <= '0;
                len_r    <= fifo_len;
            end else if (in_hs) begin
                beat_cnt <= beat_cnt + LEN'(1);
            end
            if (in_hs && (in_w_last[sel_in] != beat_last)) begin
                err_len <= 1'b1;
                $warning("wr_channel: in_w_last disagrees with command length");
            end
        end
    end
`else
    logic unused_len;

    assign beat_last  = in_w_last[sel_in];
    assign unused_len = ^fifo_len;
`endif

    always_comb begin
        in_w_ready         = '0;
        in_w_ready[sel_in] = in_rdy;
        for (int o = 0; o < OUTPUTS; o++) begin
            out_w_valid[o] = obuf_valid && (sel_out == OUTPUTSB'(o));
            out_w_last[o]  = obuf_valid && obuf_last && (sel_out == OUTPUTSB'(o));
        end
    end

    assign out_w_data = {OUTPUTS{obuf_data}};
    assign out_w_strb = {OUTPUTS{obuf_strb}};

    always @(posedge clk) begin
        if (!rst && cmd_push)
            assert (fifo_count != CNT_FULL)
            else $error("wr_channel: command pushed while FIFO full, dropped");
    end

endmodule

// File: tb/tb_dlsc_axi_router_wr_channel.sv
// Bench for the router W channel: directed table, corner sequences and randomized bursts.
module tb_dlsc_axi_router_wr_channel;
    localparam int DATA = 32, STRB = 4, LEN = 4, NI = 2, NO = 2, FA = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NI-1:0]        cmd_full_input;
    logic [NO-1:0]        cmd_full_output;
    logic                 cmd_push = 1'b0;
    logic [0:0]           cmd_input = '0;
    logic [0:0]           cmd_output = '0;
    logic [LEN-1:0]       cmd_len = '0;
    logic [NI-1:0]        in_w_ready;
    logic [NI-1:0]        in_w_valid = '0;
    logic [NI-1:0]        in_w_last = '0;
    logic [NI*DATA-1:0]   in_w_data = '0;
    logic [NI*STRB-1:0]   in_w_strb = '0;
    logic [NO-1:0]        out_w_ready = '0;
    logic [NO-1:0]        out_w_valid, out_w_last;
    logic [NO*DATA-1:0]   out_w_data;
    logic [NO*STRB-1:0]   out_w_strb;
`ifdef DLSC_AXI_ROUTER_WR_LEN_CHECK_EN
    logic                 err_len;
`endif

    dlsc_axi_router_wr_channel #(
        .DATA(DATA), .LEN(LEN), .INPUTS(NI), .INPUTSB(1),
        .OUTPUTS(NO), .OUTPUTSB(1), .FIFO_ADDR(FA)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_full_input(cmd_full_input), .cmd_full_output(cmd_full_output),
        .cmd_push(cmd_push), .cmd_input(cmd_input), .cmd_output(cmd_output), .cmd_len(cmd_len),
`ifdef DLSC_AXI_ROUTER_WR_LEN_CHECK_EN
        .err_len(err_len),
`endif
        .in_w_ready(in_w_ready), .in_w_valid(in_w_valid), .in_w_last(in_w_last),
        .in_w_data(in_w_data), .in_w_strb(in_w_strb),
        .out_w_ready(out_w_ready), .out_w_valid(out_w_valid), .out_w_last(out_w_last),
        .out_w_data(out_w_data), .out_w_strb(out_w_strb)
    );

    always #5 clk = ~clk;

    typedef struct { int port; logic [DATA-1:0] data; logic [STRB-1:0] strb; logic last; } beat_t;
    typedef struct { int in; int out; int len; bit gaps; int stall_at; int exp_beats; } vec_t;

    beat_t exp_q[$];
    int    obs_cnt[NO];
    int    n_vec = 0, n_err = 0;
    bit    mon_en = 1'b1, rand_rdy = 1'b0;
    logic [NI-1:0] s_in_rdy;
    logic [NO-1:0] s_out_vld, s_out_last, s_full_o;
    logic [NI-1:0] s_full_i;
    logic [DATA-1:0] s_out_data1;

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    // One clock: sample and score outputs at negedge, then step past the rising edge.
    task automatic cyc();
        @(negedge clk);
        s_in_rdy = in_w_ready; s_out_vld = out_w_valid; s_out_last = out_w_last;
        s_full_i = cmd_full_input; s_full_o = cmd_full_output; s_out_data1 = out_w_data[DATA +: DATA];
        if (mon_en && !rst) begin
            if (|out_w_valid) chk("valid_onehot", $countones(out_w_valid), 1);
            for (int o = 0; o < NO; o++) begin
                if (out_w_valid[o] && out_w_ready[o]) begin
                    beat_t e;
                    obs_cnt[o]++;
                    if (exp_q.size() == 0) chk("unexpected_beat_port", o, -1);
                    else begin
                        e = exp_q.pop_front();
                        chk("beat_port", o, e.port);
                        chk("beat_data", int'(out_w_data[o*DATA +: DATA]), int'(e.data));
                        chk("beat_strb", int'(out_w_strb[o*STRB +: STRB]), int'(e.strb));
                        chk("beat_last", int'(out_w_last[o]), int'(e.last));
                    end
                end
            end
        end
        @(posedge clk); #1;
        if (rand_rdy) out_w_ready = NO'($urandom);
    endtask

    task automatic push_cmd(input int i, input int o, input int l);
        cmd_push = 1'b1; cmd_input = 1'(i); cmd_output = 1'(o); cmd_len = LEN'(l);
        cyc();
        cmd_push = 1'b0;
    endtask

    task automatic send_burst(input int in, input int out, input int nb, input int last_at,
                              input bit gaps, input int stall_at);
        logic [DATA-1:0] d; logic [STRB-1:0] s; logic el;
        int t, stall; bit pend;
        pend = 1'b0; stall = 0;
        for (int b = 0; b < nb; b++) begin
            d = $urandom; s = STRB'($urandom);
`ifdef DLSC_AXI_ROUTER_WR_LEN_CHECK_EN
            el = (b == nb - 1);
`else
            el = (b == last_at);
`endif
            in_w_valid[in] = 1'b1; in_w_last[in] = (b == last_at);
            in_w_data[in*DATA +: DATA] = d; in_w_strb[in*STRB +: STRB] = s;
            exp_q.push_back('{out, d, s, el});
            if (b == stall_at) begin out_w_ready[out] = 1'b0; stall = 5; end
            t = 0;
            do begin
                cyc(); t++;
                chk("other_in_ready", int'(s_in_rdy[1-in]), 0);
                if (pend) begin chk("accept_to_out", int'(s_out_vld[out]), 1); pend = 1'b0; end
                if (stall > 0) begin
                    stall--;
                    if (stall == 0) begin
                        chk("stall_in_ready", int'(s_in_rdy[in]), 0);
                        out_w_ready[out] = 1'b1;
                    end
                end
            end while (!s_in_rdy[in] && t < 200);
            chk("in_accept", int'(s_in_rdy[in]), 1);
            in_w_valid[in] = 1'b0;
            if (!s_in_rdy[in]) return;
            pend = 1'b1;
            if (gaps && $urandom_range(3) == 0) begin
                cyc();
                chk("accept_to_out", int'(s_out_vld[out]), 1); pend = 1'b0;
            end
        end
        if (stall != 0) begin out_w_ready[out] = 1'b1; chk("stall_expired", stall, 0); end
        cyc();
        if (pend) chk("accept_to_out", int'(s_out_vld[out]), 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin cyc(); t++; end
        chk("drain_left", exp_q.size(), 0);
        exp_q.delete();
        cyc(); cyc();
    endtask

    vec_t vt[6];
    int   fill_exp[5];

    initial begin
        vt[0] = '{1, 0, 3,  1'b0, -1, 4};
        vt[1] = '{0, 1, 0,  1'b0, -1, 1};
        vt[2] = '{1, 1, 15, 1'b0, -1, 16};
        vt[3] = '{0, 1, 3,  1'b0,  2, 4};
        vt[4] = '{0, 0, 7,  1'b1, -1, 8};
        vt[5] = '{1, 0, 1,  1'b0,  0, 2};
        fill_exp = '{0, 0, 0, 1, 1};

        // reset state
        repeat (3) cyc();
        chk("rst_in_ready", int'(s_in_rdy), 0);
        chk("rst_out_valid", int'(s_out_vld), 0);
        chk("rst_out_last", int'(s_out_last), 0);
        chk("rst_full", int'({s_full_i, s_full_o}), 0);
        rst = 1'b0;
        out_w_ready = 2'b11;
        cyc();
        chk("idle_in_ready", int'(s_in_rdy), 0);
        chk("idle_out_valid", int'(s_out_vld), 0);
`ifdef DLSC_AXI_ROUTER_WR_LEN_CHECK_EN
        chk("err_len_reset", int'(err_len), 0);
`endif

        // directed table: one command at a time, beat count per port
        foreach (vt[k]) begin
            obs_cnt = '{0, 0};
            push_cmd(vt[k].in, vt[k].out, vt[k].len);
            send_burst(vt[k].in, vt[k].out, vt[k].len + 1, vt[k].len, vt[k].gaps, vt[k].stall_at);
            drain();
            chk("beats_selected", obs_cnt[vt[k].out], vt[k].exp_beats);
            chk("beats_other", obs_cnt[1 - vt[k].out], 0);
        end

        // two commands back to back
        obs_cnt = '{0, 0};
        push_cmd(0, 1, 0);
        push_cmd(1, 0, 1);
        send_burst(0, 1, 1, 0, 1'b0, -1);
        send_burst(1, 0, 2, 1, 1'b0, -1);
        drain();
        chk("b2b_out1", obs_cnt[1], 1);
        chk("b2b_out0", obs_cnt[0], 2);

        // command FIFO fill with no W traffic; one command is held by the active burst
        for (int k = 0; k < 5; k++) begin
            push_cmd(k % 2, (k + 1) % 2, 0);
            cyc();
            chk("fill_full_in", int'(s_full_i), fill_exp[k] ? 3 : 0);
            chk("fill_full_out", int'(s_full_o), fill_exp[k] ? 3 : 0);
        end
        for (int k = 0; k < 5; k++) send_burst(k % 2, (k + 1) % 2, 1, 0, 1'b0, -1);
        drain();
        chk("fill_full_after", int'({s_full_i, s_full_o}), 0);

        // reset during beat 2 of a 4-beat burst
        mon_en = 1'b0;
        push_cmd(1, 1, 3);
        in_w_valid[1] = 1'b1; in_w_last[1] = 1'b0; in_w_data[DATA +: DATA] = 32'hA5A5_0001;
        for (int t = 0; t < 20; t++) begin
            cyc();
            if (s_in_rdy[1]) break;
        end
        chk("rst_burst_beat1", int'(s_in_rdy[1]), 1);
        in_w_data[DATA +: DATA] = 32'hA5A5_0002; rst = 1'b1;
        cyc();
        chk("rst_cycle_in_ready", int'(s_in_rdy), 0);
        chk("rst_cycle_beat1_valid", int'(s_out_vld[1]), 1);
        chk("rst_cycle_beat1_data", int'(s_out_data1), 32'hA5A5_0001);
        rst = 1'b0; in_w_valid = '0;
        cyc();
        chk("post_rst_valid", int'(s_out_vld), 0);
        chk("post_rst_ready", int'(s_in_rdy), 0);
        chk("post_rst_full", int'({s_full_i, s_full_o}), 0);
        mon_en = 1'b1;
        obs_cnt = '{0, 0};
        push_cmd(0, 1, 2);
        send_burst(0, 1, 3, 2, 1'b0, -1);
        drain();
        chk("post_rst_burst", obs_cnt[1], 3);

        // randomized bursts with random output backpressure against the beat-order model
        rand_rdy = 1'b1;
        for (int g = 0; g < 20; g++) begin
            int ci[2], co[2], cl[2];
            for (int j = 0; j < 2; j++) begin
                ci[j] = $urandom_range(1); co[j] = $urandom_range(1); cl[j] = $urandom_range(5);
                push_cmd(ci[j], co[j], cl[j]);
            end
            for (int j = 0; j < 2; j++) send_burst(ci[j], co[j], cl[j] + 1, cl[j], 1'b1, -1);
        end
        drain();
        rand_rdy = 1'b0;
        out_w_ready = 2'b11;

`ifdef DLSC_AXI_ROUTER_WR_LEN_CHECK_EN
        // early in_w_last: last still on beat 4, sticky error until reset
        chk("err_len_clean", int'(err_len), 0);
        push_cmd(0, 0, 3);
        send_burst(0, 0, 4, 1, 1'b0, -1);
        drain();
        chk("err_len_set", int'(err_len), 1);
        repeat (4) cyc();
        chk("err_len_held", int'(err_len), 1);
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        chk("err_len_cleared", int'(err_len), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dlsc_axi_router_wr_channel.md
Name: dlsc_axi_router_wr_channel

Overview:
- Write-data (W) channel stage downstream of the router command stage.
- Consumes its registered command stream (cmd_push, cmd_input, cmd_output, cmd_len) and steers W beats from the selected input port to the selected output port, one burst at a time, in command order.
- Returns channel backpressure to the command stage through cmd_full_input/cmd_full_output.

Parameters:
- DATA, 32, W data width; STRB = DATA/8 (derived)
- LEN, 4, burst length field width (beats-1)
- INPUTS, 1, number of master-side input ports
- INPUTSB, 1, index width for INPUTS
- OUTPUTS, 1, number of slave-side output ports
- OUTPUTSB, 1, index width for OUTPUTS
- FIFO_ADDR, 2, command FIFO depth = 2**FIFO_ADDR (minimum 2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_full_input  out  INPUTS  command FIFO almost-full, replicated on every bit
- cmd_full_output  out  OUTPUTS  same, replicated on every bit
- cmd_push  in  1  push one command
- cmd_input  in  INPUTSB  source input index
- cmd_output  in  OUTPUTSB  destination output index
- cmd_len  in  LEN  burst beats-1
- in_w_ready  out  INPUTS  per-input W ready
- in_w_valid  in  INPUTS  per-input W valid
- in_w_last  in  INPUTS  per-input W last
- in_w_data  in  INPUTS*DATA  packed data
- in_w_strb  in  INPUTS*STRB  packed strobes
- out_w_ready  in  OUTPUTS  per-output W ready
- out_w_valid  out  OUTPUTS  per-output W valid
- out_w_last  out  OUTPUTS  per-output W last
- out_w_data  out  OUTPUTS*DATA  shared data, replicated to all outputs
- out_w_strb  out  OUTPUTS*STRB  shared strobes, replicated to all outputs

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: in_w_ready=0, out_w_valid=0, out_w_last=0, cmd_full_*=0, FIFO empty, FSM IDLE. Data/strb registers are not reset.
- Command FIFO:
  - Holds {input, output, len}; count ranges 0..DEPTH.
  - cmd_full_* = (count >= DEPTH-1). This leaves room for the one push already in flight from the registered command stage.
  - A push while count==DEPTH is a simulation assertion error and is dropped.
  - Simultaneous push and pop leaves count unchanged.
- FSM IDLE:
  - If FIFO is non-empty: pop, latch sel_in/sel_out/len, clear beat counter, go to ACTIVE next cycle (one-cycle bubble between bursts).
  - in_w_ready stays all-zero.
- FSM ACTIVE:
  - in_w_ready[sel_in] = obuf_ready, where obuf_ready = !obuf_valid || out_w_ready[sel_out]. All other ready bits are 0.
  - On handshake: capture data/strb/last into the output register and set obuf_valid. The beat appears on outputs the next cycle.
  - Throughput is one beat/cycle when out_w_ready is held high.
- Output register:
  - out_w_valid[sel_out] = obuf_valid; other valid bits are 0.
  - Clears on out_w_ready[sel_out] unless reloaded the same cycle.
  - sel_out must not change while obuf_valid is set: return to IDLE only after the last beat is accepted at the input AND drains from the output register. Waiting for drain is required; the next pop waits.
- Beat counter: LEN bits, increments per accepted beat, wraps harmlessly at 2**LEN.
- A burst of cmd_len=N carries exactly N+1 beats. Without the optional feature, termination is taken from in_w_last only.
- Reset mid-burst: all state is discarded immediately. Beats in the output register are lost; in_w_ready drops in the same cycle that rst is sampled.

Optional Feature:
- Macro: DLSC_AXI_ROUTER_WR_LEN_CHECK_EN
- With it defined:
  - Output last = (beat counter == len), independent of in_w_last.
  - Burst terminates on that beat.
  - Mismatch (in_w_last on an earlier beat, or missing on the final beat) raises sticky output err_len (1 bit, cleared only by rst) and a simulation warning.
- Without it: no err_len port; last is passed through from in_w_last and the counter is unused.

Decomposition:
- Shared package: STRB derivation, FSM state encoding (IDLE/ACTIVE), FIFO depth helper constant.
- One natural sub-module: dlsc_axi_router_cmd_fifo.
  - Synchronous FIFO with count, almost_full threshold input, and empty output.
  - Instantiated once here; reusable by the read and response channel stages.

Test Plan:
- INPUTS=2, OUTPUTS=2; push {in=1,out=0,len=3}; drive 4 beats on input 1 with last on beat 4 -> out_w_valid[0] beats 1 cycle after each accept, data order preserved, out_w_last on 4th, in_w_ready[0] always 0.
- Push 2 commands back-to-back ({0,1,0},{1,0,1}) -> 1 beat to output 1, 1 idle cycle, then 2 beats to output 0; no beat reaches the wrong port.
- FIFO_ADDR=2, no W traffic; push 3 commands -> cmd_full_* rise when count=3; one in-flight push reaches count=4 with no overflow assertion.
- Hold out_w_ready[sel]=0 for 5 cycles mid-burst -> in_w_ready[sel] drops after one buffered beat; no beat lost or duplicated when ready returns.
- Assert rst during beat 2 of a 4-beat burst -> next cycle all valid/ready low, cmd_full_* 0; a new command afterward completes normally.
- With DLSC_AXI_ROUTER_WR_LEN_CHECK_EN: len=3 and in_w_last on beat 2 -> out_w_last only on beat 4, err_len=1 and held until rst.
